// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states, default width.
package alu_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;

   typedef enum logic [3:0] {
      OP_AND     = 4'b0000,
      OP_OR      = 4'b0001,
      OP_ADD     = 4'b0010,
      OP_SLL     = 4'b0100,
      OP_SRL     = 4'b0101,
      OP_SRA     = 4'b0111,
      OP_SUB     = 4'b1000,
      OP_SLT     = 4'b1100,
      OP_SLT_ALT = 4'b1101
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } alu_state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_shift.sv
// Shifter for alu_exec_unit: one-bit-per-cycle serial shifter by default,
// combinational barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic               i_busy,
   input  logic               i_flush,
   input  logic [3:0]         i_op,
   input  logic [DATA_W-1:0]  i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   output logic               o_done,
   output logic [DATA_W-1:0]  o_result
);

`ifndef ALU_FAST_SHIFT_EN
   logic [DATA_W-1:0]  r_data;
   logic [SHAMT_W-1:0] r_count;
   alu_op_e            r_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_count <= '0;
         r_op    <= OP_SLL;
      end else if (i_flush) begin
         r_count <= '0;
      end else if (i_start) begin
         r_data  <= i_data;
         r_count <= i_shamt;
         r_op    <= alu_op_e'(i_op);
      end else if (i_busy && (r_count != '0)) begin
         case (r_op)
            OP_SLL:  r_data <= {r_data[DATA_W-2:0], 1'b0};
            OP_SRL:  r_data <= {1'b0, r_data[DATA_W-1:1]};
            default: r_data <= {r_data[DATA_W-1], r_data[DATA_W-1:1]};
         endcase
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done   = (r_count == '0);
   assign o_result = r_data;
`else
   logic w_unused;

   assign w_unused = ^{clk, rst_n, i_start, i_busy, i_flush};
   assign o_done   = 1'b1;

   always_comb begin
      case (alu_op_e'(i_op))
         OP_SLL:  o_result = i_data << i_shamt;
         OP_SRL:  o_result = i_data >> i_shamt;
         default: o_result = $unsigned($signed(i_data) >>> i_shamt);
      endcase
   end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result/zero/illegal.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts instead of the serial shifter.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        operation,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              illegal
);

   alu_state_e        r_state;
   alu_state_e        w_state_nxt;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic              r_illegal;
   logic              w_accept;
   logic              w_serial_shift;
   logic              w_start;
   logic              w_load;
   logic              w_load_ill;
   logic              w_alu_ill;
   logic              w_shift_done;
   logic [DATA_W-1:0] w_alu_res;
   logic [DATA_W-1:0] w_load_res;
   logic [DATA_W-1:0] w_shift_res;

   assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
   assign w_accept = in_valid && in_ready;

`ifndef ALU_FAST_SHIFT_EN
   assign w_serial_shift = is_shift_op(operation);
`else
   assign w_serial_shift = 1'b0;
`endif

   alu_shift_unit #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_start),
      .i_busy   (r_state == ST_SHIFT),
      .i_flush  (flush),
      .i_op     (operation),
      .i_data   (src_a),
      .i_shamt  (src_b[SHAMT_W-1:0]),
      .o_done   (w_shift_done),
      .o_result (w_shift_res)
   );

   always_comb begin
      w_alu_res = '0;
      w_alu_ill = 1'b0;
      case (alu_op_e'(operation))
         OP_AND:             w_alu_res = src_a & src_b;
         OP_OR:              w_alu_res = src_a | src_b;
         OP_ADD:             w_alu_res = src_a + src_b;
         OP_SUB:             w_alu_res = src_a - src_b;
         OP_SLT, OP_SLT_ALT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLL, OP_SRL,
         OP_SRA:             w_alu_res = w_shift_res;
         default:            w_alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_load_res  = w_alu_res;
      w_load_ill  = w_alu_ill;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_serial_shift) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
`ifndef ALU_FAST_SHIFT_EN
         ST_SHIFT: begin
            if (w_shift_done) begin
               w_load      = 1'b1;
               w_load_res  = w_shift_res;
               w_load_ill  = 1'b0;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) w_state_nxt = ST_IDLE;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_start     = 1'b0;
         w_load      = 1'b0;
      end
   end

   // A load while the old output is consumed simply replaces it, keeping out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_load_res;
         r_zero      <= (w_load_res == '0);
         r_illegal   <= w_load_ill;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases, then randomized ops against a reference model.
module tb_alu_exec_unit;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        flush     = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  operation = 4'b0000;
   logic [31:0] src_a     = '0;
   logic [31:0] src_b     = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   // dly = number of clock edges after the accepting edge before out_valid is seen
   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          acc;
      int          dly;
   } exp_t;

   exp_t q[$];
   bit   front_seen = 1'b0;
   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   rdy_mode   = 0;  // 0: always ready, 1: random, 2: stalled

   alu_exec_unit #(
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operation (operation),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   sh;
      sh    = int'(b % 32);
      e.ill = 1'b0;
      e.dly = 0;
      e.acc = 0;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b1000: e.res = a - b;
         4'b0100: begin e.res = a << sh;            e.dly = FAST ? 0 : sh + 1; end
         4'b0101: begin e.res = a >> sh;            e.dly = FAST ? 0 : sh + 1; end
         4'b0111: begin e.res = $signed(a) >>> sh;  e.dly = FAST ? 0 : sh + 1; end
         4'b1100,
         4'b1101: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: begin e.res = '0; e.ill = 1'b1; end
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   // Monitor: compares every presented output against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !out_ready) chk("held_in_ready", 32'(in_ready), 32'd0);
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               if (errors < 50)
                  $display("FAIL unexpected_output: got out_valid=1 result=0x%08h, expected no output (cycle %0d)", result, cyc);
            end else begin
               if (!front_seen) begin
                  chk("latency", 32'(cyc - q[0].acc), 32'(q[0].dly));
                  front_seen = 1'b1;
               end
               chk("result", result, q[0].res);
               chk("zero", 32'(zero), 32'(q[0].z));
               chk("illegal", 32'(illegal), 32'(q[0].ill));
               if (out_ready) begin
                  void'(q.pop_front());
                  front_seen = 1'b0;
               end
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   done;
      done      = 1'b0;
      operation = op;
      src_a     = a;
      src_b     = b;
      in_valid  = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e     = model(op, a, b);
            e.acc = cyc + 1;
            q.push_back(e);
            done  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, expected acceptance");
      end
   endtask

   task automatic wait_drain();
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 400 && !drained; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) drained = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!drained) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] codes [12];
      logic [3:0] op;
      logic [31:0] a, b;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0101,
                4'b0111, 4'b1100, 4'b1101, 4'b0011, 4'b0110, 4'b1111};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_zero", 32'(zero), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      issue(4'b0010, 32'd5, 32'd7);
      issue(4'b1000, 32'd9, 32'd9);
      wait_drain();

      issue(4'b0111, 32'h8000_0000, 32'd4);
`ifndef ALU_FAST_SHIFT_EN
      repeat (4) begin
         @(negedge clk);
         chk("shift_in_ready", 32'(in_ready), 32'd0);
      end
`endif
      wait_drain();
      issue(4'b0100, 32'h1234_5678, 32'd0);
      issue(4'b1100, 32'hFFFF_FFFF, 32'd1);
      issue(4'b1101, 32'd1, 32'hFFFF_FFFF);
      issue(4'b0110, 32'hAAAA_5555, 32'h1234_0000);
      wait_drain();

      rdy_mode = 2;
      issue(4'b0001, 32'h0000_00F0, 32'h0000_000F);
      repeat (6) @(posedge clk);
      #1;
      rdy_mode = 0;
      wait_drain();

      rdy_mode = 2;
      issue(4'b0101, $urandom(), 32'd20);
      repeat (3) @(posedge clk);
      #1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      operation = 4'b0010;
      src_a     = 32'd3;
      src_b     = 32'd3;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      void'(q.pop_back());
      front_seen = 1'b0;
      rdy_mode   = 0;
      repeat (25) @(posedge clk);
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      issue(4'b0010, 32'd1, 32'd1);
      wait_drain();

      rdy_mode = 2;
      issue(4'b0111, 32'hDEAD_BEEF, 32'd31);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_result", result, 32'd0);
      chk("midreset_zero", 32'(zero), 32'd0);
      chk("midreset_illegal", 32'(illegal), 32'd0);
      q.delete();
      front_seen = 1'b0;
      rdy_mode   = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);

      rdy_mode = 1;
      for (int n = 0; n < 300; n++) begin
         op = codes[$urandom_range(0, 11)];
         a  = $urandom();
         b  = ($urandom_range(0, 7) == 0) ? a : $urandom();
         issue(op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_mode = 0;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
